// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the serial adder reuses one instance every cycle.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built from one Full_Adder and a carry flip-flop.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_r;
  logic             fa_sum;
  logic             fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             sign_a;
  logic             sign_b;
  logic             ovf_r;
`endif

  Full_Adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let the shift see this cycle's carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SA_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        SA_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= SA_RUN;
`ifdef SERIAL_ADDER_OVF_EN
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
`endif
          end
        end
        SA_RUN: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= SA_DONE;
            cout_r <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r  <= (sign_a == sign_b) && (fa_sum != sign_a);
`endif
          end
        end
        SA_DONE: state <= SA_IDLE;
        default: state <= SA_IDLE;
      endcase
    end
  end

  assign busy = (state != SA_IDLE);
  assign done = (state == SA_DONE);
  assign sum  = sum_sr;
  assign cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_r;
`endif

endmodule
